// File: rtl/matchblock_pkg.sv
// Shared types and constants for the matchblock scheduler.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package matchblock_pkg;

  localparam int MB_DATA_W    = 10;
  localparam int MB_PNODE_W   = 138;
  // Widest source tag needed for the largest supported slot count (16).
  localparam int MB_SRC_W_MAX = 4;
  localparam logic [15:0] MB_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [MB_DATA_W-1:0]    data;
    logic [MB_SRC_W_MAX-1:0] src;
  } mb_result_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } dispatch_state_e;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == MB_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/matchblock_scheduler_if.sv
// Handshake bundle between the scheduler, the packet-node source, the slots and the result sink.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on the node path, valid/ack on the result paths.
interface matchblock_scheduler_if #(
  parameter int NUM_BLOCKS = 4,
  parameter int DATA_W     = 10,
  parameter int PNODE_W    = 138
);
  localparam int SRC_W = $clog2(NUM_BLOCKS);

  logic [PNODE_W-1:0]           pnode_data;
  logic                         pnode_valid;
  logic                         pnode_ready;

  logic [PNODE_W-1:0]           blk_pnode_data;
  logic [NUM_BLOCKS-1:0]        blk_pnode_valid;
  logic [NUM_BLOCKS-1:0]        blk_pnode_ready;

  logic [NUM_BLOCKS*DATA_W-1:0] blk_data_out;
  logic [NUM_BLOCKS-1:0]        blk_data_valid;
  logic [NUM_BLOCKS-1:0]        blk_data_ack;

  logic [DATA_W-1:0]            res_data;
  logic [SRC_W-1:0]             res_src;
  logic                         res_valid;
  logic                         res_ack;

  // Scheduler side.
  modport master (
    input  pnode_data, pnode_valid, blk_pnode_ready, blk_data_out, blk_data_valid, res_ack,
    output pnode_ready, blk_pnode_data, blk_pnode_valid, blk_data_ack, res_data, res_src, res_valid
  );

  // Environment side: node source, matchblock slots and result sink.
  modport slave (
    output pnode_data, pnode_valid, blk_pnode_ready, blk_data_out, blk_data_valid, res_ack,
    input  pnode_ready, blk_pnode_data, blk_pnode_valid, blk_data_ack, res_data, res_src, res_valid
  );

endinterface

// File: rtl/mb_rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping past N-1 back to 0.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is used.
module mb_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);
  localparam int IW  = $clog2(N);
  localparam int IW1 = IW + 1;

  logic [IW1-1:0] k;
  logic           found;

  // Walk offsets 0..N-1 from ptr; index is reduced mod N so non-power-of-2 N wraps correctly.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = '0;
    for (int i = 0; i < N; i++) begin
      k = {1'b0, ptr} + IW1'(i);
      if (k >= IW1'(N)) begin
        k = k - IW1'(N);
      end
      if (!found && req[k[IW-1:0]]) begin
        found          = 1'b1;
        grant[k[IW-1:0]] = 1'b1;
        grant_idx      = k[IW-1:0];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/matchblock_scheduler.sv
// Broadcasts packet nodes to all enabled slots and merges slot results round-robin into one stream.
// Latency: node seen by slots 1 cycle after accept; result registered 1 cycle after its ack.
// Backpressure: node held until every enabled slot took it; results wait while output reg is full and not acked.
module matchblock_scheduler
  import matchblock_pkg::*;
#(
  parameter int NUM_BLOCKS = 4,
  parameter int DATA_W     = MB_DATA_W,
  parameter int PNODE_W    = MB_PNODE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_BLOCKS-1:0] slot_enable,
  matchblock_scheduler_if.master bus,
  output logic [15:0]           bcast_count,
  output logic [15:0]           drop_count
);
  localparam int SRC_W = $clog2(NUM_BLOCKS);

  // ---------------- dispatch path ----------------
  dispatch_state_e       state;
  logic [PNODE_W-1:0]    pnode_q;
  logic [NUM_BLOCKS-1:0] pending;
  logic [NUM_BLOCKS-1:0] pending_nxt;
  logic [NUM_BLOCKS-1:0] blk_vld;
  logic                  ready_q;
  logic                  active_q;
  logic                  accept;

  assign accept      = (state == IDLE) && ready_q && bus.pnode_valid;
  // Slot valid follows slot_enable combinationally so a slot disabled mid-broadcast drops at once.
  assign blk_vld     = (state == BCAST) ? (pending & slot_enable) : '0;
  assign pending_nxt = pending & slot_enable & ~(blk_vld & bus.blk_pnode_ready);

  assign bus.pnode_ready     = ready_q;
  assign bus.blk_pnode_data  = pnode_q;
  assign bus.blk_pnode_valid = blk_vld;

  // Dispatch FSM: capture a node in IDLE, hold it in BCAST until every enabled slot has taken it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pnode_q     <= '0;
      pending     <= '0;
      ready_q     <= 1'b0;
      bcast_count <= '0;
      drop_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            pnode_q <= bus.pnode_data;
            pending <= slot_enable;
            if (slot_enable != '0) begin
              state   <= BCAST;
              ready_q <= 1'b0;
            end else begin
              drop_count <= sat_inc(drop_count);
            end
          end
        end
        BCAST: begin
          pending <= pending_nxt;
          if (pending_nxt == '0) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            bcast_count <= sat_inc(bcast_count);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Marks the first cycle after reset release; keeps the combinational ack quiet during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  // ---------------- collect path ----------------
  logic [NUM_BLOCKS-1:0] req;
  logic [NUM_BLOCKS-1:0] grant;
  logic [SRC_W-1:0]      grant_idx;
  logic [SRC_W-1:0]      rr_ptr;
  logic                  any;
  logic                  ld;
  logic [DATA_W-1:0]     res_data_q;
  logic [SRC_W-1:0]      res_src_q;
  logic                  res_valid_q;
  logic [DATA_W-1:0]     slot_dat [NUM_BLOCKS];

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_slot_dat
    assign slot_dat[i] = bus.blk_data_out[i*DATA_W +: DATA_W];
  end

  // Disabled or frozen slots never compete, even if they still hold valid.
  assign req = bus.blk_data_valid & slot_enable;

  mb_rr_arbiter #(
    .N (NUM_BLOCKS)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Load when the output register is empty or being drained this cycle.
  assign ld = active_q & (~res_valid_q | bus.res_ack) & any;

  assign bus.blk_data_ack = ld ? grant : '0;
  assign bus.res_data     = res_data_q;
  assign bus.res_src      = res_src_q;
  assign bus.res_valid    = res_valid_q;

  // Output register and round-robin pointer; pointer moves just past the slot granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q  <= '0;
      res_src_q   <= '0;
      res_valid_q <= 1'b0;
      rr_ptr      <= '0;
    end else if (ld) begin
      res_data_q  <= slot_dat[grant_idx];
      res_src_q   <= grant_idx;
      res_valid_q <= 1'b1;
      rr_ptr      <= (grant_idx == SRC_W'(NUM_BLOCKS - 1)) ? '0 : grant_idx + 1'b1;
    end else if (bus.res_ack) begin
      res_valid_q <= 1'b0;
    end
  end

endmodule

// File: doc/matchblock_scheduler.md
Name: matchblock_scheduler

Overview:
- Sits between the packet-node source and NUM_BLOCKS matchblock wrapper slots.
- Broadcasts each packet node to every enabled slot and holds it until all of those slots have accepted it.
- Gathers the 10-bit match results from the slots through a round-robin arbiter into one registered output stream tagged with the source slot.
- Slots whose wrapper is frozen or disabled (slot_enable=0) are skipped on both paths.

Parameters:
- NUM_BLOCKS, 4, number of matchblock slots (2..16)
- DATA_W, 10, match result width
- PNODE_W, 138, packet-node word width
- SRC_W, $clog2(NUM_BLOCKS), source-tag width (derived localparam)

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- slot_enable  in  NUM_BLOCKS  1 = slot enabled and not frozen
- pnode_data  in  PNODE_W  upstream packet node
- pnode_valid  in  1  upstream valid
- pnode_ready  out  1  upstream ready
- blk_pnode_data  out  PNODE_W  broadcast copy to all slots
- blk_pnode_valid  out  NUM_BLOCKS  per-slot valid
- blk_pnode_ready  in  NUM_BLOCKS  per-slot ready
- blk_data_out  in  NUM_BLOCKS*DATA_W  slot results; slot i occupies bits [i*DATA_W +: DATA_W]
- blk_data_valid  in  NUM_BLOCKS  per-slot result valid, held until acked
- blk_data_ack  out  NUM_BLOCKS  one-cycle consume pulse
- res_data  out  DATA_W  merged result
- res_src  out  SRC_W  slot index of res_data
- res_valid  out  1  merged valid
- res_ack  in  1  downstream consume
- bcast_count  out  16  nodes fully delivered (saturating)
- drop_count  out  16  nodes accepted with no enabled slot (saturating)

Behaviour:
- Reset (reset=0, async): all outputs 0, both FSMs idle, rr pointer = 0. Exception: pnode_ready deasserts asynchronously with reset and reasserts the first cycle after reset releases.

Dispatch FSM, states IDLE and BCAST:
- IDLE: pnode_ready=1. On pnode_valid:
  - pnode_q <= pnode_data; pending <= slot_enable.
  - If slot_enable != 0, go to BCAST.
  - Otherwise stay in IDLE and increment drop_count; the node is discarded.
- BCAST: pnode_ready=0; blk_pnode_data=pnode_q; blk_pnode_valid = pending & slot_enable.
  - Each cycle: pending <= pending & slot_enable & ~(blk_pnode_valid & blk_pnode_ready).
  - A slot disabled mid-broadcast is dropped from pending.
  - When the next value of pending is 0: go to IDLE and increment bcast_count.
- Latency: upstream accept in cycle t; slots see valid in t+1; earliest next accept in t+2.
- blk_pnode_data is stable for the whole of BCAST.

Collect arbiter:
- Candidates: req = blk_data_valid & slot_enable.
- Output register: res_data, res_src, res_valid.
- Load enable: ld = (!res_valid | res_ack) & (req != 0).
- Grant: g = first set bit of req, searching from rr_ptr upward with wrap-around.
- When ld is high, in the same cycle:
  - blk_data_ack[g]=1 (combinational; at most one ack bit high).
  - Next cycle: res_data=slot g data, res_src=g, res_valid=1; rr_ptr <= g+1 mod NUM_BLOCKS.
- If res_ack is high and ld is low, res_valid <= 0.
- res_valid & res_ack & ld in one cycle gives back-to-back results with no bubble: throughput of 1 result per cycle.
- A slot disabled while holding valid is never acked.
- A result already in the output register is delivered regardless of slot_enable.
- blk_data_valid sampled together with an ack counts as consumed.

Counters:
- bcast_count and drop_count saturate at 0xFFFF.

Boundaries:
- NUM_BLOCKS not a power of 2: rr_ptr wraps to 0 after NUM_BLOCKS-1.
- All slots requesting continuously: each slot granted exactly once per NUM_BLOCKS grants.

Decomposition:
- Package matchblock_pkg holds:
  - MB_DATA_W=10, MB_PNODE_W=138
  - typedef mb_result_t, containing data and src
  - typedef dispatch_state_e, with values IDLE and BCAST
- One sub-module: mb_rr_arbiter, parameterised by N.
  - Inputs: req, ptr.
  - Outputs: grant one-hot, grant index, any.
  - Purely combinational; instantiated by the collect path.

Test Plan:
- NUM_BLOCKS=4, slot_enable=4'b1111, one pnode; slots ready at cycles 1, 3, 3, 5 after broadcast -> each blk_pnode_valid drops as its slot accepts; pnode_ready=0 until the slot-3 accept, then 1 the following cycle; bcast_count=1.
- slot_enable=4'b0000, pnode_valid pulse -> accepted in 1 cycle; no blk_pnode_valid; drop_count=1; bcast_count=0.
- Broadcast pending on slot 2 (never ready); clear slot_enable[2] -> blk_pnode_valid[2] deasserts the same cycle; FSM returns to IDLE next cycle; bcast_count increments.
- All 4 slots valid with data 0x001..0x004, res_ack tied 1 -> res_src sequence 0,1,2,3; one blk_data_ack per cycle; res_valid high 4 consecutive cycles.
- res_ack=0 with res_valid=1 and slot 1 pending -> no ack issued and res_data stable; raise res_ack -> slot 1 acked in that cycle and appears next cycle.
- Assert reset mid-BCAST and with res_valid=1 -> all outputs 0 immediately; after release pnode_ready=1, counters 0, first grant starts at slot 0.
